// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock.
// Define CHUNKED_ADDER_OVF_EN to add the signed-overflow output ovf.
module chunked_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   if ((CHUNK == 0) || (WIDTH % CHUNK != 0) || (NCHUNK < 1)) begin : g_param_err
      $error("chunked_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               carry_q, carry_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   wsum_q, wsum_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic [CHUNK:0]       chunk_res;
   logic [WIDTH+CHUNK-1:0] shift_cat;
   logic                 last_chunk;
   logic                 accept;

   // Next-state and datapath: one chunk per RUN cycle, operands shift right.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      wsum_d     = wsum_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_d      = ovf_q;
`endif
      accept     = 1'b0;
      chunk_res  = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0])
                 + (CHUNK+1)'(carry_q);
      shift_cat  = {chunk_res[CHUNK-1:0], wsum_q};
      last_chunk = (cnt_q == CW'(NCHUNK - 1));

      case (state_q)
         S_IDLE: begin
            if (start) accept = 1'b1;
         end
         S_RUN: begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            wsum_d  = shift_cat[WIDTH+CHUNK-1:CHUNK];
            carry_d = chunk_res[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (last_chunk) begin
               sum_d   = shift_cat[WIDTH+CHUNK-1:CHUNK];
               cout_d  = chunk_res[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
               // Carry into the MSB is recovered from the MSB's sum bit.
               ovf_d   = (chunk_res[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1])
                       ^ chunk_res[CHUNK];
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (start) accept = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         a_d     = a;
         b_d     = sub ? ~b : b;
         carry_d = cin ^ sub;
         cnt_d   = '0;
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         wsum_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         wsum_q  <= wsum_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef CHUNKED_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign ready = (state_q != S_RUN);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder (WIDTH=32, CHUNK=8) against an arithmetic model.
module tb_chunked_adder;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CHUNK = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a, b;
   logic             cin, sub;
   logic             ready, busy, done, cout;
   logic [WIDTH-1:0] sum;
`ifdef CHUNKED_ADDER_OVF_EN
   logic             ovf;
`endif

   int tests = 0;
   int fails = 0;

   chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef CHUNKED_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer arithmetic, then reduce modulo 2^WIDTH.
   task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                        input logic ms, output logic [31:0] rs, output logic rc,
                        output logic ro);
      logic [32:0] u;
      longint      sr;
      if (!ms) begin
         u  = {1'b0, ma} + {1'b0, mb} + 33'(mc);
         rc = u[32];
         sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
      end else begin
         u  = {1'b0, ma} - {1'b0, mb} - 33'(mc);
         rc = ~u[32];
         sr = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mc);
      end
      rs = u[31:0];
      ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
   endtask

   task automatic launch(input logic [31:0] la, input logic [31:0] lb, input logic lc,
                         input logic ls);
      @(negedge clk);
      start = 1'b1; a = la; b = lb; cin = lc; sub = ls;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts edges until done, checking busy and output stability meanwhile.
   task automatic wait_done(input string tag, output int n);
      logic [31:0] held_sum;
      logic        held_cout;
      held_sum  = sum;
      held_cout = cout;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         chk({tag, "_busy"}, 64'(busy), 64'd1);
         chk({tag, "_hold"}, {31'd0, held_cout, held_sum}, {31'd0, cout, sum});
         n++;
         @(negedge clk);
      end
      chk({tag, "_timeout"}, 64'(n < 20), 64'd1);
   endtask

   task automatic check_result(input string tag, input logic [31:0] ma, input logic [31:0] mb,
                               input logic mc, input logic ms);
      logic [31:0] es;
      logic        ec, eo;
      model(ma, mb, mc, ms, es, ec, eo);
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_busy0"}, 64'(busy), 64'd0);
      chk({tag, "_ready"}, 64'(ready), 64'd1);
      chk({tag, "_sum"}, 64'(sum), 64'(es));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef CHUNKED_ADDER_OVF_EN
      chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`endif
   endtask

   task automatic full_op(input string tag, input logic [31:0] ma, input logic [31:0] mb,
                          input logic mc, input logic ms);
      int n;
      launch(ma, mb, mc, ms);
      wait_done(tag, n);
      chk({tag, "_lat"}, 64'(n), 64'd4);
      check_result(tag, ma, mb, mc, ms);
   endtask

   initial begin
      int n;
      logic [31:0] ra, rb;
      logic        rc, rs;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
`ifdef CHUNKED_ADDER_OVF_EN
      chk("rst_ovf", 64'(ovf), 64'd0);
`endif
      rst = 1'b0;

      full_op("carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      chk("carry_sum_k", 64'(sum), 64'h100);
      @(negedge clk);
      chk("carry_pulse", 64'(done), 64'd0);

      full_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      chk("wrap_cout_k", 64'(cout), 64'd1);
      full_op("wrap_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      full_op("sub_brw", 32'd5, 32'd7, 1'b0, 1'b1);
      chk("sub_brw_k", 64'(sum), 64'hFFFF_FFFE);
      full_op("sub_cin", 32'd7, 32'd5, 1'b1, 1'b1);
      chk("sub_cin_k", {63'd0, cout}, 64'd1);
      full_op("ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      full_op("ovf_sub", 32'h8000_0000, 32'd1, 1'b0, 1'b1);

      // A start pulsed during RUN must be ignored.
      launch(32'd10, 32'd20, 1'b0, 1'b0);
      start = 1'b1; a = 32'd1; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done("drop", n);
      chk("drop_lat", 64'(n + 1), 64'd4);
      check_result("drop", 32'd10, 32'd20, 1'b0, 1'b0);
      @(negedge clk);
      chk("drop_idle_done", 64'(done), 64'd0);
      chk("drop_idle_ready", 64'(ready), 64'd1);
      chk("drop_idle_busy", 64'(busy), 64'd0);

      // Back-to-back: start held in DONE.
      launch(32'd100, 32'd200, 1'b0, 1'b0);
      wait_done("b2b_a", n);
      check_result("b2b_a", 32'd100, 32'd200, 1'b0, 1'b0);
      start = 1'b1; a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done("b2b_b", n);
      chk("b2b_gap", 64'(n + 1), 64'd5);
      check_result("b2b_b", 32'd3, 32'd4, 1'b0, 1'b0);
      chk("b2b_sum_k", 64'(sum), 64'd7);

      // Reset during the second RUN cycle aborts the operation.
      launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      repeat (5) begin
         @(negedge clk);
         chk("abort_quiet", 64'(done), 64'd0);
      end
      full_op("after_abort", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = (i % 8 == 0) ? ~ra : $urandom;
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         full_op("rand", ra, rb, rc, rs);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
